// File: rtl/tm1638_pkg.sv
// tm1638_pkg: shared command encodings, bit positions, FSM states and the
// key-scan frame builder for the TM1638 responder.
package tm1638_pkg;

  localparam int RAM_DEPTH = 16;
  localparam int ADDR_W    = 4;
  localparam int KEY_BITS  = 32;

  // First-byte prefixes, bits [7:6]
  localparam logic [1:0] CMD_DATA = 2'b01;
  localparam logic [1:0] CMD_DISP = 2'b10;
  localparam logic [1:0] CMD_ADDR = 2'b11;

  // Data-command bit positions
  localparam int DATA_READ_BIT  = 1;
  localparam int DATA_FIXED_BIT = 2;

  // Display-control bit positions
  localparam int DISP_ON_BIT = 3;
  localparam int DISP_BR_MSB = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RDATA,
    ST_IGNORE
  } state_t;

  // Four key bytes sent LSB first: byte n carries S(n+1) in bit 0 and
  // S(n+5) in bit 4; the remaining bits are always zero.
  function automatic logic [KEY_BITS-1:0] key_frame(input logic [7:0] k);
    logic [KEY_BITS-1:0] f;
    f = '0;
    for (int n = 0; n < 4; n++) begin
      f[8*n]     = k[n];
      f[8*n + 4] = k[n + 4];
    end
    return f;
  endfunction

endpackage

// File: rtl/tm1638_sync_edge.sv
// tm1638_sync_edge: multi-flop synchronizer for one pin with rise/fall pulses.
// Ports: clk, rst (async active-low), d (raw pin), q (synchronized level),
//        rise/fall (one-clk pulses, valid the cycle q changes).
module tm1638_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   q_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      q_d    <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      q_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/tm1638_responder.sv
// tm1638_responder: slave side of the TM1638 STB/CLK/DIO bus.
// Ports: clk, rst (async active-low); stb/sclk/dio_in bus pins from master;
//        dio_out/dio_oe DIO drive while returning key bytes; keys[7:0] S1..S8;
//        disp_addr/disp_data registered display-RAM read port;
//        display_on/brightness display-control state;
//        disp_update pulse after a frame that wrote RAM; cmd_error pulse on a
//        first byte with prefix 00.
module tm1638_responder
  import tm1638_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RAM_DEPTH   = tm1638_pkg::RAM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stb,
  input  logic              sclk,
  input  logic              dio_in,
  output logic              dio_out,
  output logic              dio_oe,
  input  logic [7:0]        keys,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [7:0]        disp_data,
  output logic              display_on,
  output logic [2:0]        brightness,
  output logic              disp_update,
  output logic              cmd_error
);

  logic stb_s, stb_rise, stb_fall;
  logic sclk_s_unused, sclk_rise, sclk_fall;
  logic dio_s, dio_rise_unused, dio_fall_unused;

  // Idle bus level is high on every pin.
  tm1638_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_stb (
    .clk(clk), .rst(rst), .d(stb), .q(stb_s), .rise(stb_rise), .fall(stb_fall));
  tm1638_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_s_unused), .rise(sclk_rise), .fall(sclk_fall));
  tm1638_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_dio (
    .clk(clk), .rst(rst), .d(dio_in), .q(dio_s), .rise(dio_rise_unused), .fall(dio_fall_unused));

  state_t              state, state_n;
  logic [2:0]          bit_cnt;
  logic [6:0]          byte_sr;
  logic [7:0]          byte_val;
  logic [ADDR_W-1:0]   wr_addr;
  logic                fixed_mode;
  logic                frame_wrote;
  logic [KEY_BITS-1:0] rd_sr;
  logic [5:0]          rd_cnt;
  logic [7:0]          ram [RAM_DEPTH];

  logic shift_en, byte_done, wr_en, rd_last;

  // Bits are collected in every frame state except RDATA, so IGNORE keeps
  // framing without acting on anything.
  assign shift_en  = !stb_s && sclk_rise &&
                     (state == ST_CMD || state == ST_WDATA || state == ST_IGNORE);
  assign byte_done = shift_en && (bit_cnt == 3'd7);
  assign byte_val  = {dio_s, byte_sr};
  assign wr_en     = byte_done && (state == ST_WDATA);
  assign rd_last   = (rd_cnt == 6'(KEY_BITS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  // NOTE: every output of a combinational block is defaulted first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    if (stb_s) begin
      state_n = ST_IDLE;
    end else if (stb_fall) begin
      state_n = ST_CMD;
    end else begin
      case (state)
        ST_CMD: begin
          if (byte_done) begin
            case (byte_val[7:6])
              CMD_DATA: state_n = byte_val[DATA_READ_BIT] ? ST_RDATA : ST_IGNORE;
              CMD_ADDR: state_n = ST_WDATA;
              default:  state_n = ST_IGNORE;
            endcase
          end
        end
        ST_RDATA: if (sclk_fall && rd_last) state_n = ST_IGNORE;
        default:  state_n = state;
      endcase
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt     <= '0;
      byte_sr     <= '0;
      wr_addr     <= '0;
      fixed_mode  <= 1'b0;
      frame_wrote <= 1'b0;
      rd_sr       <= '0;
      rd_cnt      <= '0;
      dio_oe      <= 1'b0;
      dio_out     <= 1'b1;
      display_on  <= 1'b0;
      brightness  <= '0;
      disp_update <= 1'b0;
      cmd_error   <= 1'b0;
    end else begin
      disp_update <= 1'b0;
      cmd_error   <= 1'b0;
      if (stb_s) begin
        // Frame end or abort: drop any partial byte and release DIO.
        bit_cnt <= '0;
        rd_cnt  <= '0;
        dio_oe  <= 1'b0;
        dio_out <= 1'b1;
        if (stb_rise) begin
          disp_update <= frame_wrote;
          frame_wrote <= 1'b0;
        end
      end else begin
        if (shift_en) begin
          byte_sr <= byte_val[7:1];
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (byte_done) begin
          case (state)
            ST_CMD: begin
              case (byte_val[7:6])
                CMD_DATA: begin
                  if (byte_val[DATA_READ_BIT]) begin
                    rd_sr  <= key_frame(keys);
                    rd_cnt <= '0;
                  end else begin
                    fixed_mode <= byte_val[DATA_FIXED_BIT];
                  end
                end
                CMD_DISP: begin
                  display_on <= byte_val[DISP_ON_BIT];
                  brightness <= byte_val[DISP_BR_MSB:0];
                end
                CMD_ADDR: wr_addr   <= byte_val[ADDR_W-1:0];
                default:  cmd_error <= 1'b1;
              endcase
            end
            ST_WDATA: begin
              frame_wrote <= 1'b1;
              if (!fixed_mode) wr_addr <= wr_addr + 1'b1;
            end
            default: ;
          endcase
        end
        if (state == ST_RDATA) begin
          if (sclk_rise) rd_cnt <= rd_cnt + 6'd1;
          if (sclk_fall) begin
            if (rd_last) begin
              dio_oe  <= 1'b0;
              dio_out <= 1'b1;
            end else begin
              dio_oe  <= 1'b1;
              dio_out <= rd_sr[0];
              rd_sr   <= {1'b0, rd_sr[KEY_BITS-1:1]};
            end
          end
        end
      end
    end
  end

  // NOTE: the display RAM is cleared by reset because the emulated panel must
  // come up blank; it is small enough to live in flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RAM_DEPTH; i++) ram[i] <= '0;
      disp_data <= '0;
    end else begin
      if (wr_en) ram[wr_addr] <= byte_val;
      disp_data <= ram[disp_addr];
    end
  end

endmodule

// File: tb/tb_tm1638_responder.sv
// tb_tm1638_responder: drives TM1638 frames as a bus master and compares the
// responder against a byte-level model of the command set.
module tb_tm1638_responder;

  localparam int HALF = 6;  // clk per sclk phase, above SYNC_STAGES+2

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       stb = 1'b1;
  logic       sclk = 1'b1;
  logic       dio = 1'b1;
  logic       dio_out, dio_oe;
  logic [7:0] keys = 8'h00;
  logic [3:0] disp_addr = 4'h0;
  logic [7:0] disp_data;
  logic       display_on;
  logic [2:0] brightness;
  logic       disp_update, cmd_error;

  tm1638_responder #(.SYNC_STAGES(2), .RAM_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .stb(stb), .sclk(sclk), .dio_in(dio),
    .dio_out(dio_out), .dio_oe(dio_oe), .keys(keys),
    .disp_addr(disp_addr), .disp_data(disp_data),
    .display_on(display_on), .brightness(brightness),
    .disp_update(disp_update), .cmd_error(cmd_error));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int upd_cnt = 0;
  int err_cnt = 0;

  always @(posedge clk) begin
    if (disp_update) upd_cnt++;
    if (cmd_error)   err_cnt++;
  end

  // Model state
  logic [7:0] ram_m [16];
  logic [3:0] addr_m;
  logic       fixed_m;
  logic       on_m;
  logic [2:0] br_m;
  int         upd_exp = 0;
  int         err_exp = 0;
  logic [7:0] frame_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) ram_m[i] = 8'h00;
    addr_m = 4'h0; fixed_m = 1'b0; on_m = 1'b0; br_m = 3'd0;
  endtask

  // Applies one complete frame (first byte = command) to the model.
  task automatic model_frame();
    logic [7:0] c;
    if (frame_q.size() == 0) return;
    c = frame_q[0];
    case (c[7:6])
      2'b00: err_exp++;
      2'b01: if (!c[1]) fixed_m = c[2];
      2'b10: begin on_m = c[3]; br_m = c[2:0]; end
      default: begin
        addr_m = c[3:0];
        for (int i = 1; i < frame_q.size(); i++) begin
          ram_m[addr_m] = frame_q[i];
          if (!fixed_m) addr_m = addr_m + 4'd1;
        end
        if (frame_q.size() > 1) upd_exp++;
      end
    endcase
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b0; dio = b[i];
      wait_clk(HALF);
      sclk = 1'b1;
      wait_clk(HALF);
    end
  endtask

  task automatic send_frame();
    stb = 1'b0;
    wait_clk(HALF);
    foreach (frame_q[i]) send_bits(frame_q[i], 8);
    dio = 1'b1;
    stb = 1'b1;
    wait_clk(2 * HALF);
    model_frame();
  endtask

  task automatic frame1(input logic [7:0] a);
    frame_q = {a};
    send_frame();
  endtask

  task automatic read_ram(input logic [3:0] k, output logic [7:0] d);
    disp_addr = k;
    wait_clk(1);
    d = disp_data;
  endtask

  task automatic check_state(input string tag);
    logic [7:0] d;
    for (int k = 0; k < 16; k++) begin
      read_ram(4'(k), d);
      check($sformatf("%s ram[%0d]", tag, k), {24'h0, d}, {24'h0, ram_m[k]});
    end
    check({tag, " display_on"}, {31'h0, display_on}, {31'h0, on_m});
    check({tag, " brightness"}, {29'h0, brightness}, {29'h0, br_m});
    check({tag, " disp_update count"}, upd_cnt, upd_exp);
    check({tag, " cmd_error count"}, err_cnt, err_exp);
  endtask

  // Read frame: keys are changed after the command to confirm the latch.
  task automatic read_frame(input string tag, input logic [7:0] k);
    logic [7:0] got [4];
    logic [7:0] exp;
    logic       oe_ok;
    oe_ok = 1'b1;
    keys = k;
    stb = 1'b0;
    wait_clk(HALF);
    send_bits(8'h42, 8);
    dio = 1'b1;
    keys = 8'($urandom);
    for (int b = 0; b < 32; b++) begin
      sclk = 1'b0;
      wait_clk(HALF);
      if (dio_oe !== 1'b1) oe_ok = 1'b0;
      got[b / 8][b % 8] = dio_out;
      sclk = 1'b1;
      wait_clk(HALF);
    end
    check({tag, " oe during read"}, {31'h0, oe_ok}, 32'h1);
    for (int n = 0; n < 4; n++) begin
      exp = (k[n] ? 8'h01 : 8'h00) | (k[n + 4] ? 8'h10 : 8'h00);
      check($sformatf("%s key byte %0d", tag, n), {24'h0, got[n]}, {24'h0, exp});
    end
    sclk = 1'b0;
    wait_clk(HALF);
    check({tag, " oe after 32 bits"}, {31'h0, dio_oe}, 32'h0);
    sclk = 1'b1;
    wait_clk(HALF);
    stb = 1'b1;
    wait_clk(2 * HALF);
    check({tag, " oe stb high"}, {31'h0, dio_oe}, 32'h0);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] v;
    model_reset();

    // Reset values while rst held low
    wait_clk(3);
    check("rst dio_oe", {31'h0, dio_oe}, 32'h0);
    check("rst dio_out", {31'h0, dio_out}, 32'h1);
    check("rst disp_update", {31'h0, disp_update}, 32'h0);
    check("rst cmd_error", {31'h0, cmd_error}, 32'h0);
    rst = 1'b1;
    wait_clk(HALF);

    // Put state in place, then reset in the middle of a key read
    frame1(8'h8F);
    frame_q = {8'hC0, 8'h11, 8'h22};
    send_frame();
    check_state("pre-reset");
    keys = 8'hFF;
    stb = 1'b0;
    wait_clk(HALF);
    send_bits(8'h42, 8);
    for (int i = 0; i < 3; i++) begin
      sclk = 1'b0; wait_clk(HALF); sclk = 1'b1; wait_clk(HALF);
    end
    sclk = 1'b0;
    wait_clk(HALF);
    check("mid-read oe before reset", {31'h0, dio_oe}, 32'h1);
    rst = 1'b0;
    #1;
    check("async rst dio_oe", {31'h0, dio_oe}, 32'h0);
    check("async rst dio_out", {31'h0, dio_out}, 32'h1);
    check("async rst display_on", {31'h0, display_on}, 32'h0);
    check("async rst brightness", {29'h0, brightness}, 32'h0);
    check("async rst disp_data", {24'h0, disp_data}, 32'h0);
    sclk = 1'b1; stb = 1'b1;
    wait_clk(HALF);
    rst = 1'b1;
    model_reset();
    wait_clk(HALF);
    check_state("post-reset");

    // Auto-increment write of 0..15
    frame1(8'h40);
    frame_q = {8'hC0};
    for (int k = 0; k < 16; k++) frame_q.push_back(8'(k));
    send_frame();
    check_state("auto");

    // Fixed address then wrap-around
    frame1(8'h44);
    frame_q = {8'hC5, 8'hAA, 8'h55};
    send_frame();
    read_ram(4'd5, d);
    check("fixed ram[5]", {24'h0, d}, 32'h55);
    read_ram(4'd6, d);
    check("fixed ram[6]", {24'h0, d}, 32'h06);
    frame1(8'h40);
    frame_q = {8'hCE, 8'h01, 8'h02, 8'h03};
    send_frame();
    read_ram(4'd14, d); check("wrap ram[14]", {24'h0, d}, 32'h01);
    read_ram(4'd15, d); check("wrap ram[15]", {24'h0, d}, 32'h02);
    read_ram(4'd0, d);  check("wrap ram[0]", {24'h0, d}, 32'h03);
    check_state("wrap");

    // Key read
    read_frame("keys81", 8'b1000_0001);

    // Display control
    frame1(8'h8B);
    check("disp 8B on", {31'h0, display_on}, 32'h1);
    check("disp 8B br", {29'h0, brightness}, 32'h3);
    frame1(8'h80);
    check("disp 80 on", {31'h0, display_on}, 32'h0);
    check("disp 80 br", {29'h0, brightness}, 32'h0);

    // Error command
    frame1(8'h00);
    check_state("error");

    // Aborted write byte
    stb = 1'b0;
    wait_clk(HALF);
    send_bits(8'hC3, 8);
    send_bits(8'h1F, 5);
    stb = 1'b1;
    wait_clk(2 * HALF);
    frame_q = {8'hC3};
    model_frame();
    check_state("abort");

    // STB glitch with no clocks
    stb = 1'b0; wait_clk(HALF); stb = 1'b1; wait_clk(2 * HALF);
    check_state("glitch");

    // Randomized frames
    for (int it = 0; it < 16; it++) begin
      case ($urandom_range(0, 3))
        0: frame1(8'h40 | 8'($urandom_range(0, 1) << 2) | 8'($urandom_range(0, 1) << 3));
        1: begin
          frame_q = {8'hC0 | 8'($urandom_range(0, 15))};
          for (int n = 0; n < $urandom_range(1, 6); n++) begin
            v = 8'($urandom);
            frame_q.push_back(v);
          end
          send_frame();
        end
        2: frame1(8'h80 | 8'($urandom_range(0, 15)));
        default: read_frame($sformatf("rnd%0d", it), 8'($urandom));
      endcase
      check_state($sformatf("rnd%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
